// File: rtl/herald_mac_pkg.sv
// herald_mac_pkg: shared definitions for the MAC engine.
//   - command opcode encoding
//   - FSM state encoding
//   - saturating-add outcome helper
package herald_mac_pkg;

    // Command opcodes
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MAC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    // FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MULT = 2'd1;
    localparam state_t ST_ACC  = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    // Outcome of an accumulator add.
    // clamp: replace the sum with all-ones.
    // ovf:   set the channel's sticky flag.
    typedef struct packed {
        logic clamp;
        logic ovf;
    } sat_ctl_t;

    // The caller computes the sum one bit wider than the accumulator.
    // carry is that extra top bit. A carry always raises overflow. It
    // clamps only when saturation is enabled; otherwise the sum wraps.
    function automatic sat_ctl_t sat_add_ctl(input logic carry, input logic saturate);
        sat_ctl_t r;
        r.ovf   = carry;
        r.clamp = carry & saturate;
        return r;
    endfunction

endpackage

// File: rtl/herald_seq_mult.sv
// herald_seq_mult: iterative unsigned shift-add multiplier.
// Processes one multiplier bit per clock, LSB first.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   sampled at a rising edge; latches a and b and clears the product
//   a, b    in   DATA_W-bit operands
//   done    out  high during the cycle whose closing edge is the DATA_W-th after start;
//                product is final after that edge
//   product out  2*DATA_W-bit result
module herald_seq_mult #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic                run_q, run_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;

    assign done    = run_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign product = prod_q;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/herald_mac_engine.sv
// herald_mac_engine: multi-channel unsigned multiply/accumulate engine.
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; accepted only in IDLE
//   cmd_op                    00 MUL, 01 MAC, 10 CLR, 11 READ
//   cmd_ch, cmd_a, cmd_b      target channel and operands, latched at accept
//   rsp_valid/rsp_ready       response handshake; payload held until accepted
//   rsp_data, rsp_ch, rsp_ovf result, originating channel, channel sticky overflow
//   busy                      engine not idle
module herald_mac_engine
    import herald_mac_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned NUM_CH   = 4,
    parameter bit          SATURATE = 1'b1,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ACC_W-1:0]  rsp_data,
    output logic [CH_W-1:0]   rsp_ch,
    output logic              rsp_ovf,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [ACC_W-1:0]    rsp_data_q, rsp_data_d;
    logic                rsp_ovf_q, rsp_ovf_d;
    logic [ACC_W-1:0]    acc_q [NUM_CH];
    logic [ACC_W-1:0]    acc_d [NUM_CH];
    logic [NUM_CH-1:0]   sticky_q, sticky_d;

    logic                  mult_start;
    logic                  mult_done;
    logic [2*DATA_W-1:0]   mult_product;

    // Channel being addressed this cycle. In IDLE it is the live command;
    // later it is the latched one.
    logic [CH_W-1:0]  sel_ch;
    logic             ch_ok;
    logic [ACC_W-1:0] acc_sel;
    logic             sticky_sel;
    logic [ACC_W:0]   sum;
    sat_ctl_t         sat;
    logic [ACC_W-1:0] mac_val;

    herald_seq_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (mult_start),
        .a       (cmd_a),
        .b       (cmd_b),
        .done    (mult_done),
        .product (mult_product)
    );

    assign sel_ch = (state_q == ST_IDLE) ? cmd_ch : ch_q;
    assign ch_ok  = 32'(sel_ch) < NUM_CH;

    always_comb begin
        acc_sel    = '0;
        sticky_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(sel_ch) == i) begin
                acc_sel    = acc_q[i];
                sticky_sel = sticky_q[i];
            end
        end
    end

    assign sum     = {1'b0, acc_sel} + (ACC_W + 1)'(mult_product);
    assign sat     = sat_add_ctl(sum[ACC_W], SATURATE);
    assign mac_val = sat.clamp ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ch_d       = ch_q;
        rsp_data_d = rsp_data_q;
        rsp_ovf_d  = rsp_ovf_q;
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        mult_start = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    ch_d = cmd_ch;
                    unique case (cmd_op)
                        OP_MUL, OP_MAC: begin
                            mult_start = 1'b1;
                            state_d    = ST_MULT;
                        end
                        OP_CLR: begin
                            rsp_data_d = '0;
                            rsp_ovf_d  = 1'b0;
                            for (int unsigned i = 0; i < NUM_CH; i++) begin
                                if (ch_ok && 32'(sel_ch) == i) begin
                                    acc_d[i]    = '0;
                                    sticky_d[i] = 1'b0;
                                end
                            end
                            state_d = ST_RESP;
                        end
                        OP_READ: begin
                            rsp_data_d = ch_ok ? acc_sel : '0;
                            rsp_ovf_d  = ch_ok & sticky_sel;
                            state_d    = ST_RESP;
                        end
                    endcase
                end
            end
            ST_MULT: begin
                if (mult_done) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                state_d = ST_RESP;
                if (!ch_ok) begin
                    rsp_data_d = '0;
                    rsp_ovf_d  = 1'b0;
                end else if (op_q == OP_MAC) begin
                    rsp_data_d = mac_val;
                    rsp_ovf_d  = sticky_sel | sat.ovf;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (32'(sel_ch) == i) begin
                            acc_d[i]    = mac_val;
                            sticky_d[i] = sticky_sel | sat.ovf;
                        end
                    end
                end else begin
                    rsp_data_d = ACC_W'(mult_product);
                    rsp_ovf_d  = sticky_sel;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MUL;
            ch_q       <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            sticky_q   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ch_q       <= ch_d;
            rsp_data_q <= rsp_data_d;
            rsp_ovf_q  <= rsp_ovf_d;
            sticky_q   <= sticky_d;
            acc_q      <= acc_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_ch    = ch_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_herald_mac_engine.sv
module tb_herald_mac_engine;
    import herald_mac_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam longint      ACC_MAX = (longint'(1) << ACC_W) - 1;
    localparam int          LAT_MULT = DATA_W + 1;  // edges after accept, MUL/MAC
    localparam int          LAT_DIRECT = 0;         // CLR/READ visible right after accept

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [CH_W-1:0]   cmd_ch;
    logic [DATA_W-1:0] cmd_a, cmd_b;
    logic              rsp_ready;

    // Saturating instance (s) and wrapping instance (w) share all inputs.
    logic              cmd_ready, rsp_valid, rsp_ovf, busy;
    logic [ACC_W-1:0]  rsp_data;
    logic [CH_W-1:0]   rsp_ch;
    logic              cmd_ready_w, rsp_valid_w, rsp_ovf_w, busy_w;
    logic [ACC_W-1:0]  rsp_data_w;
    logic [CH_W-1:0]   rsp_ch_w;

    always #5 clk = ~clk;

    herald_mac_engine #(
        .DATA_W (DATA_W), .ACC_W (ACC_W), .NUM_CH (NUM_CH), .SATURATE (1'b1)
    ) dut_s (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op),
        .cmd_ch (cmd_ch), .cmd_a (cmd_a), .cmd_b (cmd_b),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
        .rsp_ch (rsp_ch), .rsp_ovf (rsp_ovf), .busy (busy)
    );

    herald_mac_engine #(
        .DATA_W (DATA_W), .ACC_W (ACC_W), .NUM_CH (NUM_CH), .SATURATE (1'b0)
    ) dut_w (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready_w), .cmd_op (cmd_op),
        .cmd_ch (cmd_ch), .cmd_a (cmd_a), .cmd_b (cmd_b),
        .rsp_valid (rsp_valid_w), .rsp_ready (rsp_ready), .rsp_data (rsp_data_w),
        .rsp_ch (rsp_ch_w), .rsp_ovf (rsp_ovf_w), .busy (busy_w)
    );

    typedef struct {
        int     ch;
        longint d_sat;
        bit     o_sat;
        longint d_wrap;
        bit     o_wrap;
    } exp_t;

    exp_t   sb[$];
    longint acc_s [NUM_CH];
    longint acc_w [NUM_CH];
    bit     stk_s [NUM_CH];
    bit     stk_w [NUM_CH];

    int checks   = 0;
    int failures = 0;
    logic [ACC_W-1:0] last_data, last_data_w;
    logic             last_ovf, last_ovf_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            acc_s[i] = 0; acc_w[i] = 0; stk_s[i] = 0; stk_w[i] = 0;
        end
        sb.delete();
    endtask

    task automatic model(input logic [1:0] op, input int ch, input int a, input int b);
        exp_t   e;
        longint p, s;
        p    = longint'(a) * longint'(b);
        e.ch = ch;
        case (op)
            OP_MUL: begin
                e.d_sat = p; e.o_sat = stk_s[ch]; e.d_wrap = p; e.o_wrap = stk_w[ch];
            end
            OP_MAC: begin
                s = acc_s[ch] + p;
                if (s > ACC_MAX) begin acc_s[ch] = ACC_MAX; stk_s[ch] = 1; end
                else acc_s[ch] = s;
                s = acc_w[ch] + p;
                if (s > ACC_MAX) begin acc_w[ch] = s & ACC_MAX; stk_w[ch] = 1; end
                else acc_w[ch] = s;
                e.d_sat = acc_s[ch]; e.o_sat = stk_s[ch];
                e.d_wrap = acc_w[ch]; e.o_wrap = stk_w[ch];
            end
            OP_CLR: begin
                acc_s[ch] = 0; stk_s[ch] = 0; acc_w[ch] = 0; stk_w[ch] = 0;
                e.d_sat = 0; e.o_sat = 0; e.d_wrap = 0; e.o_wrap = 0;
            end
            default: begin
                e.d_sat = acc_s[ch]; e.o_sat = stk_s[ch];
                e.d_wrap = acc_w[ch]; e.o_wrap = stk_w[ch];
            end
        endcase
        sb.push_back(e);
    endtask

    // Called at a falling edge; the command is accepted at the next rising edge.
    task automatic issue(input logic [1:0] op, input int ch, input int a, input int b,
                         input bit track);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = CH_W'(ch);
        cmd_a     = DATA_W'(a);
        cmd_b     = DATA_W'(b);
        if (track) model(op, ch, a, b);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Operands were latched at accept; scrambling them must not matter.
        cmd_a = DATA_W'($urandom);
        cmd_b = DATA_W'($urandom);
    endtask

    task automatic collect(input int lat_exp, input int hold, input bit poke);
        int   k;
        exp_t e;
        k = 0;
        @(negedge clk);
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", 64'(k), 64'(lat_exp));
        if (!rsp_valid) return;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_underflow observed=response expected=none");
            return;
        end
        e = sb.pop_front();
        check("rsp_data", rsp_data, 64'(e.d_sat));
        check("rsp_ch", rsp_ch, 64'(e.ch));
        check("rsp_ovf", rsp_ovf, 64'(e.o_sat));
        check("rsp_data_wrap", rsp_data_w, 64'(e.d_wrap));
        check("rsp_ovf_wrap", rsp_ovf_w, 64'(e.o_wrap));
        check("busy_resp", busy, 1'b1);
        check("cmd_ready_resp", cmd_ready, 1'b0);
        last_data = rsp_data; last_data_w = rsp_data_w;
        last_ovf  = rsp_ovf;  last_ovf_w  = rsp_ovf_w;
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                cmd_valid = 1'b1; cmd_op = OP_CLR; cmd_ch = CH_W'(e.ch);
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data", rsp_data, 64'(e.d_sat));
            check("hold_ch", rsp_ch, 64'(e.ch));
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", rsp_valid, 1'b0);
        check("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    function automatic int lat_of(input logic [1:0] op);
        return (op == OP_MUL || op == OP_MAC) ? LAT_MULT : LAT_DIRECT;
    endfunction

    task automatic txn(input logic [1:0] op, input int ch, input int a, input int b);
        issue(op, ch, a, b, 1'b1);
        collect(lat_of(op), 0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_MUL; cmd_ch = '0;
        cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
        model_reset();
        #12;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_ch", rsp_ch, 0);
        check("reset_rsp_ovf", rsp_ovf, 1'b0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single multiply, accumulator untouched
        txn(OP_MUL, 0, 8'hFF, 8'hFF);
        check("t1_product", last_data, 24'h00FE01);
        txn(OP_READ, 0, 0, 0);
        check("t1_read_ch0", last_data, 0);

        // 2: accumulate on ch1
        txn(OP_MAC, 1, 3, 5);
        check("t2_mac1", last_data, 15);
        txn(OP_MAC, 1, 3, 5);
        check("t2_mac2", last_data, 30);
        txn(OP_READ, 1, 0, 0);
        txn(OP_READ, 0, 0, 0);

        // 3: saturation vs wrap on ch2
        for (int i = 0; i < 258; i++) txn(OP_MAC, 2, 8'hFF, 8'hFF);
        check("t3_mac258", last_data, 16776450);
        check("t3_mac258_ovf", last_ovf, 1'b0);
        txn(OP_MAC, 2, 8'hFF, 8'hFF);
        check("t3_sat_data", last_data, 24'hFFFFFF);
        check("t3_sat_ovf", last_ovf, 1'b1);
        check("t3_wrap_data", last_data_w, 24'h00FB03);
        check("t3_wrap_ovf", last_ovf_w, 1'b1);
        txn(OP_READ, 2, 0, 0);
        txn(OP_CLR, 2, 0, 0);
        check("t3_clr_ovf", last_ovf, 1'b0);
        txn(OP_READ, 2, 0, 0);

        // 4: backpressure with a dropped command in the hold window
        rsp_ready = 1'b0;
        issue(OP_MAC, 3, 2, 7, 1'b1);
        collect(LAT_MULT, 5, 1'b1);
        check("t4_data", last_data, 14);
        txn(OP_READ, 3, 0, 0);
        check("t4_read_ch3", last_data, 14);

        // 5: reset during MULT aborts the command
        issue(OP_MAC, 1, 10, 10, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rsp_valid", rsp_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        txn(OP_READ, 1, 0, 0);
        check("t5_read_ch1", last_data, 0);

        // 6: back-to-back reads, rsp_ready held high
        txn(OP_READ, 0, 0, 0);
        txn(OP_READ, 1, 0, 0);
        check("t6_last_ch", rsp_ch, 1);
        check("t6_sb_drained", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
